// File: rtl/hi_lo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, CALC, FIX} muldiv_state_t;

  typedef enum logic {OP_MUL, OP_DIV} muldiv_op_t;

endpackage

// File: rtl/hi_lo_muldiv_unit_iter_core.sv
// Iterative datapath: LSB-first shift-add multiply and restoring divide,
// one step per enabled cycle on unsigned magnitudes.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product,
  output logic [WIDTH-1:0]   o_quotient,
  output logic [WIDTH-1:0]   o_remainder
);

  // r_acc is the product high half (multiply) or the partial remainder
  // (divide); r_q is the shifting multiplier or the dividend/quotient.
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, (r_q[0] ? r_b : {WIDTH{1'b0}})};
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_q   <= '0;
      r_b   <= '0;
    end else if (i_load) begin
      r_acc <= '0;
      r_q   <= i_a;
      r_b   <= i_b;
    end else if (i_step) begin
      if (i_is_div) begin
        // Partial remainder is always below the divisor, so a clear MSB of
        // the difference means the trial subtraction fits.
        if (!w_diff[WIDTH]) begin
          r_acc <= w_diff[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b1};
        end else begin
          r_acc <= w_shift[WIDTH-1:0];
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_acc <= w_sum[WIDTH:1];
        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
      end
    end
  end

  assign o_product   = {r_acc, r_q};
  assign o_quotient  = r_q;
  assign o_remainder = r_acc;

endmodule

// File: rtl/hi_lo_muldiv_unit.sv
// HI/LO multiply/divide sequencer: decodes MULT/DIV/MTHI/MTLO, runs the
// iterative core, applies sign correction and owns the HI/LO pair.
module hi_lo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_lo_read,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  muldiv_state_t r_state;
  muldiv_state_t w_state_nxt;
  muldiv_op_t    r_op;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [WIDTH-1:0] r_raw_a;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  logic [2*WIDTH-1:0] w_product;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  always_comb begin
    w_is_mul = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    w_is_div = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    w_signed = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    w_accept = start && !abort && (r_state == IDLE);
    w_load   = w_accept && (w_is_mul || w_is_div);
    w_step   = (r_state == CALC) && !abort;
    w_a_mag  = (w_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    w_b_mag  = (w_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
  end

  muldiv_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_is_div    (r_op == OP_DIV),
    .i_a         (w_a_mag),
    .i_b         (w_b_mag),
    .o_product   (w_product),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_nxt = CALC;
        end else if (w_accept && w_is_div) begin
          w_state_nxt = (operand_b == '0) ? FIX : CALC;
        end
      end
      CALC:    if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Result-sign fix-up applied on the way into HI/LO.
  always_comb begin
    w_prod_fix = r_neg_q ? -w_product : w_product;
    w_quot_fix = r_neg_q ? -w_quotient : w_quotient;
    w_rem_fix  = r_neg_r ? -w_remainder : w_remainder;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_MUL;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_raw_a <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_op    <= w_is_div ? OP_DIV : OP_MUL;
        r_cnt   <= CNT_W'(WIDTH);
        r_neg_q <= w_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        r_neg_r <= w_signed && operand_a[WIDTH-1];
        r_div0  <= w_is_div && (operand_b == '0);
        r_raw_a <= operand_a;
      end else if (w_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (r_state == FIX && !abort) begin
        r_done <= 1'b1;
        if (r_op == OP_MUL) begin
          {r_hi, r_lo} <= w_prod_fix;
        end else if (r_div0) begin
          r_hi <= r_raw_a;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quot_fix;
        end
      end else if (w_accept && funct == FUNCT_MTHI) begin
        r_hi <= operand_a;
      end else if (w_accept && funct == FUNCT_MTLO) begin
        r_lo <= operand_a;
      end
    end
  end

  assign busy  = (r_state != IDLE);
  assign stall = busy && (start || hi_lo_read);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// Scoreboard bench for hi_lo_muldiv_unit: expected HI/LO pairs are queued at
// issue and checked by a monitor whenever done pulses.
module tb_hi_lo_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        hi_lo_read;
  logic        abort;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int nvec = 0;
  int errs = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  hi_lo_muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .funct      (funct),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .hi_lo_read (hi_lo_read),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        errs++;
        $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        check("done_result", {hi, lo}, sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    funct = f;
    operand_a = a;
    operand_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts sampling cycles after the issue edge until done, and busy cycles seen.
  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) break;
      if (n >= 100) begin
        nvec++;
        errs++;
        $display("FAIL done_timeout: got no done in %0d cycles, expected done", n);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, miss;
    rst_n = 1'b0;
    start = 1'b0;
    funct = '0;
    operand_a = '0;
    operand_b = '0;
    hi_lo_read = 1'b0;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_flags", {61'h0, busy, done, stall}, 64'h0);
    rst_n = 1'b1;

    // Busy spans from the issue edge to the edge that writes HI/LO.
    sb.push_back({32'hFFFFFFFE, 32'h00000001});
    issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n, nb);
    check("mul_latency", 64'(n), 64'd34);
    check("mul_busy_cycles", 64'(nb), 64'd33);
    @(posedge clk); #1;

    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
    issue(F_MULT, 32'hFFFFFFFD, 32'd7);
    wait_done(n, nb);
    @(posedge clk); #1;

    sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(F_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done(n, nb);
    @(posedge clk); #1;

    sb.push_back({32'd100, 32'hFFFFFFFF});
    issue(F_DIVU, 32'd100, 32'd0);
    wait_done(n, nb);
    check("div0_latency", 64'(n), 64'd2);
    @(posedge clk); #1;

    sb.push_back({32'h00000000, 32'h80000000});
    issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(n, nb);
    @(posedge clk); #1;

    // MFHI/MFLO read while dividing.
    sb.push_back({32'd2, 32'd14});
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    hi_lo_read = 1'b1;
    miss = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
      if (!stall) miss++;
    end
    check("read_stall_held", 64'(miss), 64'd0);
    check("read_stall_done_cycle", {63'h0, stall}, 64'h0);
    check("read_sees_new", {hi, lo}, {32'd2, 32'd14});
    @(posedge clk); #1;
    check("read_stall_after", {63'h0, stall}, 64'h0);
    hi_lo_read = 1'b0;

    // MTHI held off by an in-flight MULT, then re-presented.
    sb.push_back({32'h00000000, 32'd30});
    issue(F_MULT, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1;
    funct = F_MTHI;
    operand_a = 32'h00001234;
    operand_b = 32'h0;
    miss = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) break;
      if (!stall) miss++;
    end
    check("mthi_stall_held", 64'(miss), 64'd0);
    check("mthi_stall_done_cycle", {63'h0, stall}, 64'h0);
    @(posedge clk); #1;
    start = 1'b0;
    check("mthi_applied", {hi, lo}, {32'h00001234, 32'd30});

    // Abort mid-CALC: no done, HI/LO untouched.
    issue(F_MULT, 32'd3, 32'd3);
    repeat (18) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_hilo", {hi, lo}, {32'h00001234, 32'd30});
    repeat (40) @(posedge clk);
    #1;
    check("abort_hilo_later", {hi, lo}, {32'h00001234, 32'd30});

    start = 1'b1; funct = F_MTLO; operand_a = 32'hDEADDEAD; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_beats_mtlo", {hi, lo}, {32'h00001234, 32'd30});

    issue(F_MTLO, 32'h0000BEEF, 32'h0);
    check("mtlo_write", {hi, lo}, {32'h00001234, 32'h0000BEEF});
    check("mtlo_flags", {62'h0, busy, done}, 64'h0);

    issue(6'b100000, 32'h11111111, 32'h22222222);
    check("ignored_funct", {31'h0, busy, hi}, {31'h0, 1'b0, 32'h00001234});

    // Asynchronous reset during CALC.
    issue(F_MULTU, 32'h0000FFFF, 32'h0000FFFF);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_hilo", {hi, lo}, 64'h0);
    check("async_rst_flags", {62'h0, busy, done}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_idle", {31'h0, busy, hi}, 64'h0);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
